// File: rtl/pcie_ss_rst_seq_pkg.sv
// Shared types and helpers for the per-link PCIe subsystem reset sequencer.
//   t_rst_seq_state : per-link sequencing state
//   t_rst_mode      : reset flavour currently being sequenced
//   cnt_width()     : width needed to hold the largest of four cycle counts
package pcie_ss_rst_seq_pkg;

    typedef enum logic [2:0] {
        StAssert,
        StHold,
        StRelease,
        StReady,
        StFault
    } t_rst_seq_state;

    typedef enum logic {
        ModeCold,
        ModeWarm
    } t_rst_mode;

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pcie_ss_rst_seq_if.sv
// Subsystem-side reset handshake pins, one bit per link.
//   ss_cold_rst_n / ss_warm_rst_n         : resets driven by the sequencer, active low
//   ss_cold_rst_ack_n / ss_warm_rst_ack_n : acknowledges from the subsystem, active low
//   ss_reset_status                       : high while the subsystem link is in reset
// master = sequencer side, slave = subsystem side.
interface pcie_ss_rst_seq_if #(
    parameter int unsigned PCIE_NUM_LINKS = 1
);
    logic [PCIE_NUM_LINKS-1:0] ss_cold_rst_n;
    logic [PCIE_NUM_LINKS-1:0] ss_warm_rst_n;
    logic [PCIE_NUM_LINKS-1:0] ss_cold_rst_ack_n;
    logic [PCIE_NUM_LINKS-1:0] ss_warm_rst_ack_n;
    logic [PCIE_NUM_LINKS-1:0] ss_reset_status;

    modport master (
        output ss_cold_rst_n,
        output ss_warm_rst_n,
        input  ss_cold_rst_ack_n,
        input  ss_warm_rst_ack_n,
        input  ss_reset_status
    );

    modport slave (
        input  ss_cold_rst_n,
        input  ss_warm_rst_n,
        output ss_cold_rst_ack_n,
        output ss_warm_rst_ack_n,
        output ss_reset_status
    );
endinterface

// File: rtl/pcie_ss_rst_seq_link_fsm.sv
// One link of the reset sequencer: state machine, wait/hold counter, sticky timeout error.
//   fim_clk, fim_rst               : clock, synchronous active-high reset
//   cold_rst_req, warm_rst_req     : level reset requests
//   cold_rst_ack_n, warm_rst_ack_n : subsystem acknowledges, active low
//   reset_status                   : subsystem still in reset
//   err_clr                        : clear sticky error, restart from FAULT
//   release_grant                  : arbiter permission to leave HOLD
//   release_eligible               : hold time met and no request pending
//   cold_rst_n, warm_rst_n         : registered reset outputs
//   link_ready, rst_timeout_err    : registered status
//   in_ready                       : state is READY (feeds the top-level busy flag)
module pcie_ss_rst_link_fsm
    import pcie_ss_rst_seq_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT_CYCLES = 4096,
    parameter int unsigned COLD_HOLD_CYCLES   = 64,
    parameter int unsigned WARM_HOLD_CYCLES   = 16,
    parameter int unsigned CNT_W              = 13
) (
    input  logic fim_clk,
    input  logic fim_rst,
    input  logic cold_rst_req,
    input  logic warm_rst_req,
    input  logic cold_rst_ack_n,
    input  logic warm_rst_ack_n,
    input  logic reset_status,
    input  logic err_clr,
    input  logic release_grant,
    output logic release_eligible,
    output logic cold_rst_n,
    output logic warm_rst_n,
    output logic link_ready,
    output logic rst_timeout_err,
    output logic in_ready
);

    localparam logic [CNT_W:0] ACK_LIM  = (CNT_W + 1)'(ACK_TIMEOUT_CYCLES);
    localparam logic [CNT_W:0] COLD_LIM = (CNT_W + 1)'(COLD_HOLD_CYCLES);
    localparam logic [CNT_W:0] WARM_LIM = (CNT_W + 1)'(WARM_HOLD_CYCLES);

    t_rst_seq_state   state_q, state_d;
    t_rst_mode        mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d, err_set;
    logic             cold_rst_n_q, warm_rst_n_q, link_ready_q;

    logic [CNT_W:0]   cnt_inc, hold_lim;
    logic             ack_seen, rel_seen, ack_expired, hold_done, escalate, same_req;

    // A wait/hold expires on the cycle whose increment would reach the limit, so the
    // state occupies exactly LIMIT cycles.
    always_comb begin
        cnt_inc     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        hold_lim    = (mode_q == ModeCold) ? COLD_LIM : WARM_LIM;
        ack_expired = (cnt_inc >= ACK_LIM);
        hold_done   = (cnt_inc >= hold_lim);
        ack_seen    = (mode_q == ModeCold) ? !cold_rst_ack_n : !warm_rst_ack_n;
        rel_seen    = ((mode_q == ModeCold) ? cold_rst_ack_n : warm_rst_ack_n) && !reset_status;
        escalate    = cold_rst_req && (mode_q == ModeWarm);
        same_req    = (mode_q == ModeCold) ? cold_rst_req : warm_rst_req;
        release_eligible = (state_q == StHold) && hold_done && !cold_rst_req && !warm_rst_req;
        in_ready    = (state_q == StReady);
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        err_set = 1'b0;
        unique case (state_q)
            StReady: begin
                if (cold_rst_req) begin
                    state_d = StAssert;
                    mode_d  = ModeCold;
                    cnt_d   = '0;
                end else if (warm_rst_req) begin
                    state_d = StAssert;
                    mode_d  = ModeWarm;
                    cnt_d   = '0;
                end
            end
            StAssert: begin
                if (escalate) begin
                    mode_d = ModeCold;
                    cnt_d  = '0;
                end else if (ack_seen) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end else if (ack_expired) begin
                    // Missing acknowledge is flagged but the sequence carries on.
                    err_set = 1'b1;
                    state_d = StHold;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
            end
            StHold: begin
                if (escalate) begin
                    state_d = StAssert;
                    mode_d  = ModeCold;
                    cnt_d   = '0;
                end else if (release_grant) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end else if ({1'b0, cnt_q} < hold_lim) begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
            end
            StRelease: begin
                if (escalate || same_req) begin
                    // Warm request in cold mode is absorbed; cold always lands in cold mode.
                    state_d = StAssert;
                    mode_d  = cold_rst_req ? ModeCold : mode_q;
                    cnt_d   = '0;
                end else if (rel_seen) begin
                    state_d = StReady;
                end else if (ack_expired) begin
                    err_set = 1'b1;
                    state_d = StFault;
                end else begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
            end
            StFault: begin
                if (err_clr || cold_rst_req) begin
                    state_d = StAssert;
                    mode_d  = ModeCold;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StAssert;
                mode_d  = ModeCold;
                cnt_d   = '0;
            end
        endcase
        // A new timeout beats a simultaneous clear.
        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge fim_clk) begin
        if (fim_rst) begin
            state_q      <= StAssert;
            mode_q       <= ModeCold;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            cold_rst_n_q <= 1'b0;
            warm_rst_n_q <= 1'b1;
            link_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            cold_rst_n_q <= !(((state_q == StAssert) || (state_q == StHold)) &&
                              (mode_q == ModeCold));
            warm_rst_n_q <= !(((state_q == StAssert) || (state_q == StHold)) &&
                              (mode_q == ModeWarm));
            link_ready_q <= (state_q == StReady);
        end
    end

    assign cold_rst_n      = cold_rst_n_q;
    assign warm_rst_n      = warm_rst_n_q;
    assign link_ready      = link_ready_q;
    assign rst_timeout_err = err_q;

endmodule

// File: rtl/pcie_ss_rst_seq.sv
// Multi-link PCIe subsystem reset sequencer top.
//   fim_clk, fim_rst             : clock, synchronous active-high reset
//   cold_rst_req, warm_rst_req   : per-link level reset requests
//   err_clr                      : per-link sticky error clear / fault restart
//   link_ready, rst_timeout_err  : per-link status
//   busy                         : any link not in READY
//   ss                           : subsystem reset handshake pins
// Owns the release arbiter: lowest eligible link wins, then STAGGER_CYCLES of gap before
// the next release. With STAGGER_CYCLES = 0 every eligible link is released at once.
module pcie_ss_rst_seq
    import pcie_ss_rst_seq_pkg::*;
#(
    parameter int unsigned PCIE_NUM_LINKS     = 1,
    parameter int unsigned ACK_TIMEOUT_CYCLES = 4096,
    parameter int unsigned COLD_HOLD_CYCLES   = 64,
    parameter int unsigned WARM_HOLD_CYCLES   = 16,
    parameter int unsigned STAGGER_CYCLES     = 8
) (
    input  logic                      fim_clk,
    input  logic                      fim_rst,
    input  logic [PCIE_NUM_LINKS-1:0] cold_rst_req,
    input  logic [PCIE_NUM_LINKS-1:0] warm_rst_req,
    input  logic [PCIE_NUM_LINKS-1:0] err_clr,
    output logic [PCIE_NUM_LINKS-1:0] link_ready,
    output logic [PCIE_NUM_LINKS-1:0] rst_timeout_err,
    output logic                      busy,
    pcie_ss_rst_seq_if.master         ss
);

    localparam int unsigned CNT_W = cnt_width(ACK_TIMEOUT_CYCLES, COLD_HOLD_CYCLES,
                                              WARM_HOLD_CYCLES, STAGGER_CYCLES);
    localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYCLES);

    logic [PCIE_NUM_LINKS-1:0] eligible, grant, in_ready;
    logic [PCIE_NUM_LINKS-1:0] cold_n_vec, warm_n_vec;
    logic [CNT_W-1:0]          stagger_q, stagger_d;
    logic                      busy_q;

    for (genvar i = 0; i < PCIE_NUM_LINKS; i++) begin : g_link
        pcie_ss_rst_link_fsm #(
            .ACK_TIMEOUT_CYCLES (ACK_TIMEOUT_CYCLES),
            .COLD_HOLD_CYCLES   (COLD_HOLD_CYCLES),
            .WARM_HOLD_CYCLES   (WARM_HOLD_CYCLES),
            .CNT_W              (CNT_W)
        ) u_link (
            .fim_clk          (fim_clk),
            .fim_rst          (fim_rst),
            .cold_rst_req     (cold_rst_req[i]),
            .warm_rst_req     (warm_rst_req[i]),
            .cold_rst_ack_n   (ss.ss_cold_rst_ack_n[i]),
            .warm_rst_ack_n   (ss.ss_warm_rst_ack_n[i]),
            .reset_status     (ss.ss_reset_status[i]),
            .err_clr          (err_clr[i]),
            .release_grant    (grant[i]),
            .release_eligible (eligible[i]),
            .cold_rst_n       (cold_n_vec[i]),
            .warm_rst_n       (warm_n_vec[i]),
            .link_ready       (link_ready[i]),
            .rst_timeout_err  (rst_timeout_err[i]),
            .in_ready         (in_ready[i])
        );
    end

    assign ss.ss_cold_rst_n = cold_n_vec;
    assign ss.ss_warm_rst_n = warm_n_vec;

    // The reload cycle counts as the first gap cycle, so a grant is allowed again once
    // the counter is about to reach zero; releases then land exactly STAGGER_CYCLES apart.
    always_comb begin
        grant     = '0;
        stagger_d = stagger_q;
        if (stagger_q != '0) stagger_d = stagger_q - CNT_W'(1);
        if (STAGGER_CYCLES == 0) begin
            grant = eligible;
        end else if (stagger_q <= CNT_W'(1)) begin
            grant = eligible & (~eligible + PCIE_NUM_LINKS'(1));
            if (|eligible) stagger_d = STAGGER_LOAD;
        end
    end

    always_ff @(posedge fim_clk) begin
        if (fim_rst) begin
            stagger_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            stagger_q <= stagger_d;
            busy_q    <= ~&in_ready;
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_pcie_ss_rst_seq.sv
// Directed bench for pcie_ss_rst_seq.
// Timing model: outputs are registered decodes of the state register, so a state entered
// at edge e shows on the pins after edge e+1. cyc counts edges since the last cyc = 0.
module tb_pcie_ss_rst_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: two links, default timing, staggered release.
    logic       a_rst = 1'b1;
    logic [1:0] a_cold_req = '0, a_warm_req = '0, a_err_clr = '0;
    logic [1:0] a_ready, a_err;
    logic       a_busy;
    pcie_ss_rst_seq_if #(.PCIE_NUM_LINKS(2)) ifa ();

    pcie_ss_rst_seq #(
        .PCIE_NUM_LINKS (2),
        .STAGGER_CYCLES (8)
    ) dut_a (
        .fim_clk         (clk),
        .fim_rst         (a_rst),
        .cold_rst_req    (a_cold_req),
        .warm_rst_req    (a_warm_req),
        .err_clr         (a_err_clr),
        .link_ready      (a_ready),
        .rst_timeout_err (a_err),
        .busy            (a_busy),
        .ss              (ifa.master)
    );

    // Instance B: four links, no staggering.
    logic       b_rst = 1'b1;
    logic [3:0] b_cold_req = '0, b_warm_req = '0, b_err_clr = '0;
    logic [3:0] b_ready, b_err;
    logic       b_busy;
    pcie_ss_rst_seq_if #(.PCIE_NUM_LINKS(4)) ifb ();

    pcie_ss_rst_seq #(
        .PCIE_NUM_LINKS (4),
        .STAGGER_CYCLES (0)
    ) dut_b (
        .fim_clk         (clk),
        .fim_rst         (b_rst),
        .cold_rst_req    (b_cold_req),
        .warm_rst_req    (b_warm_req),
        .err_clr         (b_err_clr),
        .link_ready      (b_ready),
        .rst_timeout_err (b_err),
        .busy            (b_busy),
        .ss              (ifb.master)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   cold_dropped;
        int   ack_edge;

        ifa.ss_cold_rst_ack_n = '1;
        ifa.ss_warm_rst_ack_n = '1;
        ifa.ss_reset_status   = '1;
        ifb.ss_cold_rst_ack_n = '1;
        ifb.ss_warm_rst_ack_n = '1;
        ifb.ss_reset_status   = '1;

        // ---------------- Reset values
        repeat (3) tick();
        check("rst_cold_n", ifa.ss_cold_rst_n, 32'h0);
        check("rst_warm_n", ifa.ss_warm_rst_n, 32'h3);
        check("rst_ready", a_ready, 32'h0);
        check("rst_err", a_err, 32'h0);
        check("rst_busy", a_busy, 32'h1);

        // ---------------- Power-on: acks at cyc 3, sampled edge 4 = HOLD entry.
        // Cold hold 64 -> RELEASE at 68, pin high after 69; link1 8 cycles later.
        a_rst = 1'b0;
        cyc   = 0;
        repeat (3) tick();
        check("po_cold_n_pre_ack", ifa.ss_cold_rst_n, 32'h0);
        ifa.ss_cold_rst_ack_n = 2'b00;
        for (int k = 0; k < 200 && ifa.ss_cold_rst_n[0] !== 1'b1; k++) tick();
        check("po_l0_release_cyc", cyc, 69);
        check("po_l1_still_low", ifa.ss_cold_rst_n[1], 32'h0);
        ifa.ss_cold_rst_ack_n[0] = 1'b1;
        ifa.ss_reset_status[0]   = 1'b0;
        for (int k = 0; k < 200 && ifa.ss_cold_rst_n[1] !== 1'b1; k++) tick();
        check("po_l1_release_cyc", cyc, 77);
        ifa.ss_cold_rst_ack_n[1] = 1'b1;
        ifa.ss_reset_status[1]   = 1'b0;
        repeat (2) tick();
        check("po_ready", a_ready, 32'h3);
        check("po_busy", a_busy, 32'h0);
        check("po_err", a_err, 32'h0);
        check("po_warm_n", ifa.ss_warm_rst_n, 32'h3);

        // ---------------- Warm reset on link0: request sampled at edge 1 -> pin low after 2.
        // Ack driven 5 cycles later, sampled at edge 8; hold 16 -> pin high 17 edges later.
        cyc = 0;
        a_warm_req[0] = 1'b1;
        tick();
        a_warm_req[0] = 1'b0;
        for (int k = 0; k < 20 && ifa.ss_warm_rst_n[0] !== 1'b0; k++) tick();
        check("warm_low_cyc", cyc, 2);
        repeat (5) tick();
        ifa.ss_warm_rst_ack_n[0] = 1'b0;
        ifa.ss_reset_status[0]   = 1'b1;
        ack_edge = cyc + 1;
        cold_dropped = 1'b0;
        for (int k = 0; k < 100 && ifa.ss_warm_rst_n[0] !== 1'b1; k++) begin
            tick();
            if (ifa.ss_cold_rst_n[0] !== 1'b1) cold_dropped = 1'b1;
        end
        check("warm_high_after_ack", cyc - ack_edge, 17);
        check("warm_cold_untouched", cold_dropped, 32'h0);
        check("warm_ready_low", a_ready[0], 32'h0);
        ifa.ss_warm_rst_ack_n[0] = 1'b1;
        ifa.ss_reset_status[0]   = 1'b0;
        repeat (2) tick();
        check("warm_ready_back", a_ready, 32'h3);

        // ---------------- Cold escalation from WARM HOLD.
        cyc = 0;
        a_warm_req[0] = 1'b1;
        tick();
        a_warm_req[0] = 1'b0;
        ifa.ss_warm_rst_ack_n[0] = 1'b0;
        ifa.ss_reset_status[0]   = 1'b1;
        repeat (4) tick();
        a_cold_req[0] = 1'b1;
        tick();
        check("esc_before_warm_n", ifa.ss_warm_rst_n[0], 32'h0);
        check("esc_before_cold_n", ifa.ss_cold_rst_n[0], 32'h1);
        a_cold_req[0] = 1'b0;
        ifa.ss_warm_rst_ack_n[0] = 1'b1;
        tick();
        check("esc_swap_pins", {ifa.ss_warm_rst_n[0], ifa.ss_cold_rst_n[0]}, 32'h2);
        ifa.ss_cold_rst_ack_n[0] = 1'b0;
        for (int k = 0; k < 200 && ifa.ss_cold_rst_n[0] !== 1'b1; k++) tick();
        check("esc_cold_hold_cyc", cyc, 73);
        ifa.ss_cold_rst_ack_n[0] = 1'b1;
        ifa.ss_reset_status[0]   = 1'b0;
        repeat (2) tick();
        check("esc_ready", a_ready[0], 32'h1);

        // ---------------- ASSERT timeout on link1 (ack never arrives), then RELEASE timeout.
        cyc = 0;
        a_cold_req[1] = 1'b1;
        ifa.ss_reset_status[1] = 1'b1;
        tick();
        a_cold_req[1] = 1'b0;
        for (int k = 0; k < 5000 && a_err[1] !== 1'b1; k++) tick();
        check("to_assert_err_cyc", cyc, 4097);
        a_err_clr[1] = 1'b1;
        tick();
        a_err_clr[1] = 1'b0;
        check("to_err_cleared", a_err[1], 32'h0);
        while (cyc < 4161) tick();
        check("to_hold_still_low", ifa.ss_cold_rst_n[1], 32'h0);
        tick();
        check("to_released", ifa.ss_cold_rst_n[1], 32'h1);
        // RELEASE entered at 4161, status stuck -> timeout at edge 8257; clear lands there too.
        while (cyc < 8256) tick();
        check("to_rel_err_pre", a_err[1], 32'h0);
        a_err_clr[1] = 1'b1;
        tick();
        a_err_clr[1] = 1'b0;
        check("to_set_beats_clr", a_err[1], 32'h1);
        tick();
        check("fault_cold_n", ifa.ss_cold_rst_n[1], 32'h1);
        check("fault_warm_n", ifa.ss_warm_rst_n[1], 32'h1);
        check("fault_ready", a_ready[1], 32'h0);
        check("fault_busy", a_busy, 32'h1);
        repeat (2) tick();
        check("fault_sticky", a_err[1], 32'h1);
        a_err_clr[1] = 1'b1;
        tick();
        a_err_clr[1] = 1'b0;
        tick();
        check("fault_restart_cold_n", ifa.ss_cold_rst_n[1], 32'h0);
        check("fault_restart_err", a_err[1], 32'h0);
        ifa.ss_cold_rst_ack_n[1] = 1'b0;
        for (int k = 0; k < 200 && ifa.ss_cold_rst_n[1] !== 1'b1; k++) tick();
        check("fault_reseq_cyc", cyc, 8328);
        ifa.ss_cold_rst_ack_n[1] = 1'b1;
        ifa.ss_reset_status[1]   = 1'b0;
        repeat (2) tick();
        check("fault_reseq_ready", a_ready, 32'h3);

        // ---------------- Four links, no stagger: all release together.
        check("b_rst_busy", b_busy, 32'h1);
        check("b_rst_warm_n", ifb.ss_warm_rst_n, 32'hf);
        b_rst = 1'b0;
        cyc   = 0;
        repeat (3) tick();
        ifb.ss_cold_rst_ack_n = 4'h0;
        for (int k = 0; k < 200 && ifb.ss_cold_rst_n === 4'h0; k++) tick();
        check("b_release_cyc", cyc, 69);
        check("b_release_all", ifb.ss_cold_rst_n, 32'hf);
        ifb.ss_cold_rst_ack_n = 4'hf;
        ifb.ss_reset_status   = 4'h0;
        repeat (2) tick();
        check("b_ready_all", b_ready, 32'hf);
        check("b_busy_idle", b_busy, 32'h0);

        // fim_rst while link0 sits in HOLD.
        b_cold_req[0] = 1'b1;
        tick();
        b_cold_req[0] = 1'b0;
        ifb.ss_cold_rst_ack_n = 4'b1110;
        ifb.ss_reset_status[0] = 1'b1;
        repeat (2) tick();
        check("b_hold_cold_n", ifb.ss_cold_rst_n, 32'he);
        check("b_hold_ready", b_ready, 32'he);
        b_rst = 1'b1;
        tick();
        check("b_mid_rst_cold_n", ifb.ss_cold_rst_n, 32'h0);
        check("b_mid_rst_warm_n", ifb.ss_warm_rst_n, 32'hf);
        check("b_mid_rst_ready", b_ready, 32'h0);
        check("b_mid_rst_err", b_err, 32'h0);
        check("b_mid_rst_busy", b_busy, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pcie_ss_rst_seq.md
# pcie_ss_rst_seq

Per-link reset sequencer for the multi-link PCIe subsystem. Sits between FIM reset/power management and the subsystem's cold/warm reset request/acknowledge pins. It converts level reset requests into fully handshaked assert, hold and release sequences for up to four links, with:
- cold-over-warm escalation;
- acknowledge timeouts with sticky errors;
- staggered release across links, so that links do not leave reset in the same cycle.

## Interface
Parameters:
- PCIE_NUM_LINKS, 1: number of links (1..4)
- ACK_TIMEOUT_CYCLES, 4096: maximum wait for any acknowledge edge (>=2)
- COLD_HOLD_CYCLES, 64: minimum cold-reset low time after acknowledge
- WARM_HOLD_CYCLES, 16: minimum warm-reset low time after acknowledge
- STAGGER_CYCLES, 8: minimum gap between two link releases; 0 disables staggering

Ports:
- fim_clk  in  1  sole clock
- fim_rst  in  1  synchronous, active-high reset
- cold_rst_req  in  [N]  level cold-reset request per link
- warm_rst_req  in  [N]  level warm-reset request per link
- ss_cold_rst_n  out  [N]  subsystem cold reset, active low
- ss_warm_rst_n  out  [N]  subsystem warm reset, active low
- ss_cold_rst_ack_n  in  [N]  subsystem cold acknowledge, active low
- ss_warm_rst_ack_n  in  [N]  subsystem warm acknowledge, active low
- ss_reset_status  in  [N]  subsystem per-link reset status, high while in reset
- err_clr  in  [N]  one-cycle clear of the sticky error; also restarts a faulted link
- link_ready  out  [N]  link out of reset and released
- rst_timeout_err  out  [N]  sticky acknowledge-timeout error
- busy  out  1  OR of (state != READY) over all links

## Operation
Per-link state machine: ASSERT, HOLD, RELEASE, READY, FAULT. Each link also holds a mode register, COLD or WARM.

- **Reset.** fim_rst forces every link to ASSERT/COLD with counters cleared. Output values during reset:
  - ss_cold_rst_n = 0, ss_warm_rst_n = 1
  - link_ready = 0, rst_timeout_err = 0, busy = 1
  - The first post-reset sequence is therefore a cold reset of every link.
- **READY.**
  - cold_rst_req -> ASSERT/COLD.
  - Otherwise warm_rst_req -> ASSERT/WARM.
  - If both are high, cold wins.
- **ASSERT.**
  - Drives the mode's rst_n low and the other rst_n high.
  - Waits for the mode's ack_n = 0, then goes to HOLD with the hold counter cleared.
  - If the wait counter reaches ACK_TIMEOUT_CYCLES: set rst_timeout_err and go to HOLD anyway.
- **HOLD.**
  - rst_n stays low.
  - The counter saturates at the mode's hold count.
  - The link is eligible for release when the count is done and both requests are low.
  - It leaves HOLD only on a release grant.
- **RELEASE.**
  - The mode's rst_n goes high.
  - Waits for ack_n = 1 and ss_reset_status = 0, then goes to READY (link_ready = 1).
  - On timeout: set the error and go to FAULT.
- **FAULT.**
  - Both rst_n are held high and link_ready = 0.
  - err_clr or cold_rst_req -> ASSERT/COLD.
- **Escalation.** cold_rst_req while in WARM mode, in any of ASSERT, HOLD or RELEASE:
  - switch to COLD, restart ASSERT, clear counters;
  - ss_warm_rst_n returns high in the same cycle ss_cold_rst_n goes low.
- **Absorbed request.** warm_rst_req during a COLD sequence is ignored.
- **Release grant.**
  - Among eligible links, the lowest index wins.
  - After a grant, the stagger counter loads STAGGER_CYCLES and no further grant is issued until it reaches 0.
  - With STAGGER_CYCLES = 0, all eligible links are granted in the same cycle.
- **err_clr.**
  - Clears the sticky error.
  - If err_clr and a new timeout fall in the same cycle, the set wins.
- **Counters.** Width is $clog2(max parameter + 1). They never wrap: they saturate.

## Timing
- All outputs are registered.
- A request sampled high in READY at edge t -> rst_n low after edge t+1.
- Acknowledge sampled at edge t -> HOLD from t+1.
- Hold of H cycles plus an immediate grant -> rst_n high H+1 cycles after HOLD entry.
- Release completion sampled at edge t -> link_ready high after edge t+1.
- Timeout: error asserts exactly ACK_TIMEOUT_CYCLES cycles after entering the waiting state.
- A request re-asserted in RELEASE (same mode):
  - in WARM mode, warm_rst_req -> back to ASSERT;
  - in COLD mode, cold_rst_req -> back to ASSERT.
- fim_rst asserted mid-sequence -> immediate return to the reset values on the next edge.

## Structure
- pcie_ss_rst_seq_pkg contains:
  - t_rst_seq_state (ASSERT, HOLD, RELEASE, READY, FAULT);
  - t_rst_mode (COLD, WARM);
  - a counter-width function.
- Sub-module pcie_ss_rst_link_fsm holds one link's FSM, counters and error flag; the top instantiates it PCIE_NUM_LINKS times.
- The top owns the release-grant arbiter and the stagger counter.

## Test plan
- **Power-on, N=2, acks after 3 cycles:** both links cold-sequence. Link0 is released at hold+1, link1 exactly 8 cycles later; both link_ready = 1; no errors.
- **Warm request on link0 in READY, ack after 5 cycles:**
  - ss_warm_rst_n low for 5 + 16 cycles;
  - ss_cold_rst_n stays 1;
  - link_ready returns to 1 after ack deasserts.
- **Cold escalation:** cold_rst_req while link0 is in WARM HOLD -> warm_rst_n goes high and cold_rst_n goes low on the same edge; the 64-cycle hold is enforced.
- **ASSERT timeout:** ack never asserts -> rst_timeout_err set at cycle 4096, the sequence continues. Then err_clr and a timeout set in the same cycle -> the error stays 1.
- **RELEASE timeout:** ss_reset_status stuck at 1 -> FAULT with link_ready = 0. err_clr -> a new cold sequence starts.
- **STAGGER_CYCLES = 0, N = 4, identical acks:** all four links are released in the same cycle. fim_rst mid-HOLD -> reset values on the next edge.
